// File: rtl/iob_split_tmo_pkg.sv
// Shared types and sizing helpers for the IOb request splitter with timeout.
package iob_split_tmo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  // Registered request is {valid, addr, wdata, wstrb}; response is {err, data}.
  function automatic int req_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  function automatic int resp_w(input int data_w);
    return data_w + 1;
  endfunction

  localparam int REQ_W  = req_w(32, 32);
  localparam int RESP_W = resp_w(32);

endpackage

// File: rtl/iob_split_tmo_if.sv
// Native-bus bundle between one master, the splitter and its slave ports.
interface iob_split_tmo_if #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int N_SLAVES = 4
);
  logic                         m_valid;
  logic [ADDR_W-1:0]            m_addr;
  logic [DATA_W-1:0]            m_wdata;
  logic [DATA_W/8-1:0]          m_wstrb;
  logic [DATA_W-1:0]            m_rdata;
  logic                         m_ready;
  logic [N_SLAVES-1:0]          s_valid;
  logic [ADDR_W-1:0]            s_addr;
  logic [DATA_W-1:0]            s_wdata;
  logic [DATA_W/8-1:0]          s_wstrb;
  logic [N_SLAVES*DATA_W-1:0]   s_rdata;
  logic [N_SLAVES-1:0]          s_ready;
  logic [15:0]                  err_cnt;
  logic [ADDR_W-1:0]            err_addr;
  logic                         err_tmo;

  // The splitter is the slave of the CPU side.
  modport slave (
    input  m_valid, m_addr, m_wdata, m_wstrb, s_rdata, s_ready,
    output m_rdata, m_ready, s_valid, s_addr, s_wdata, s_wstrb,
    output err_cnt, err_addr, err_tmo
  );

  modport master (
    output m_valid, m_addr, m_wdata, m_wstrb, s_rdata, s_ready,
    input  m_rdata, m_ready, s_valid, s_addr, s_wdata, s_wstrb,
    input  err_cnt, err_addr, err_tmo
  );
endinterface

// File: rtl/iob_split_tmo_cnt.sv
// Per-transaction timeout counter: counts enabled cycles, flags expiry at all-ones.
module iob_split_tmo_cnt #(
  parameter int TMO_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic exp_o
);
  logic [TMO_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign exp_o = en_i && (cnt_q == '1);
endmodule

// File: rtl/iob_split_tmo.sv
// Routes one master request to a slave chosen by an address field; unmapped
// selects and hung slaves complete with an error response and are logged.
module iob_split_tmo
  import iob_split_tmo_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              N_SLAVES = 4,
  parameter int              SEL_W    = 2,
  parameter int              P_SLAVES = ADDR_W - 2,
  parameter int              REQ_REG  = 0,
  parameter int              TMO_W    = 8,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEF
) (
  input logic            clk,
  input logic            rst_n,
  iob_split_tmo_if.slave bus
);
  localparam int STRB_W    = DATA_W / 8;
  localparam int REQ_BITS  = req_w(ADDR_W, DATA_W);
  localparam int RESP_BITS = resp_w(DATA_W);

  // state | meaning
  // IDLE  | waiting for m_valid; select decoded and latched on acceptance
  // BUSY  | request out on s_valid[sel]; waiting for s_ready[sel] or timeout
  // ERR   | unmapped select; error completion this cycle
  state_t                state_q, state_d;
  logic [N_SLAVES-1:0]   sel_oh_q, sel_oh_in, s_sel;
  logic [ADDR_W-1:0]     addr_q, err_addr_q, req_addr;
  logic [DATA_W-1:0]     rdata_q, rdata_sel, req_wdata;
  logic [STRB_W-1:0]     req_wstrb;
  logic [15:0]           err_cnt_q;
  logic                  err_tmo_q;
  logic [SEL_W-1:0]      sel_in;
  logic [RESP_BITS-1:0]  resp;
  logic                  mapped, acc, done, is_tmo, rdy_sel, tmo_exp, s_vld_any;

  assign sel_in = bus.m_addr[P_SLAVES -: SEL_W];

  always_comb begin
    sel_oh_in = '0;
    rdata_sel = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      sel_oh_in[k] = (sel_in == SEL_W'(k));
      if (sel_oh_q[k]) rdata_sel = rdata_sel | bus.s_rdata[k*DATA_W +: DATA_W];
    end
  end

  assign mapped  = |sel_oh_in;
  assign rdy_sel = |(bus.s_ready & sel_oh_q);

  // rst_n gates acceptance so a held m_valid never reaches a slave during reset.
  always_comb begin
    state_d = state_q;
    acc     = 1'b0;
    done    = 1'b0;
    is_tmo  = 1'b0;
    resp    = {1'b0, rdata_q};
    case (state_q)
      IDLE: begin
        if (bus.m_valid && rst_n) begin
          acc     = 1'b1;
          state_d = mapped ? BUSY : ERR;
        end
      end
      BUSY: begin
        if (rdy_sel) begin
          done    = 1'b1;
          resp    = {1'b0, rdata_sel};
          state_d = IDLE;
        end else if (tmo_exp) begin
          done    = 1'b1;
          is_tmo  = 1'b1;
          resp    = {1'b1, ERR_DATA};
          state_d = IDLE;
        end
      end
      ERR: begin
        done    = 1'b1;
        resp    = {1'b1, ERR_DATA};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_oh_q   <= '0;
      addr_q     <= '0;
      rdata_q    <= '0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
      err_tmo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (acc) begin
        sel_oh_q <= sel_oh_in;
        addr_q   <= bus.m_addr;
      end
      if (done) rdata_q <= resp[DATA_W-1:0];
      if (done && resp[DATA_W]) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
        err_addr_q <= addr_q;
        err_tmo_q  <= is_tmo;
      end
    end
  end

  if (TMO_W > 0) begin : g_tmo
    iob_split_tmo_cnt #(.TMO_W(TMO_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (state_q != BUSY),
      .en_i  ((state_q == BUSY) && !rdy_sel),
      .exp_o (tmo_exp)
    );
  end else begin : g_no_tmo
    assign tmo_exp = 1'b0;
  end

  if (REQ_REG != 0) begin : g_req_reg
    logic [REQ_BITS-1:0] req_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        req_q <= '0;
      end else if (acc && mapped) begin
        req_q <= {1'b1, bus.m_addr, bus.m_wdata, bus.m_wstrb};
      end else if (done) begin
        req_q[REQ_BITS-1] <= 1'b0;
      end
    end

    assign s_vld_any = req_q[REQ_BITS-1] & bus.m_valid;
    assign s_sel     = sel_oh_q;
    assign {req_addr, req_wdata, req_wstrb} = req_q[REQ_BITS-2:0];
  end else begin : g_req_comb
    assign s_vld_any = bus.m_valid & ((acc & mapped) | (state_q == BUSY));
    assign s_sel     = (state_q == BUSY) ? sel_oh_q : sel_oh_in;
    assign req_addr  = bus.m_addr;
    assign req_wdata = bus.m_wdata;
    assign req_wstrb = bus.m_wstrb;
  end

  assign bus.s_valid  = s_vld_any ? s_sel : '0;
  assign bus.s_addr   = req_addr;
  assign bus.s_wdata  = req_wdata;
  assign bus.s_wstrb  = s_vld_any ? req_wstrb : '0;
  assign bus.m_ready  = done;
  assign bus.m_rdata  = resp[DATA_W-1:0];
  assign bus.err_cnt  = err_cnt_q;
  assign bus.err_addr = err_addr_q;
  assign bus.err_tmo  = err_tmo_q;
endmodule

// File: tb/tb_iob_split_tmo.sv
// Bench for iob_split_tmo: unit 0 is 4 slaves / combinational request, unit 1
// is 3 slaves / registered request; both use a 4-bit timeout and top-bit select.
module tb_iob_split_tmo;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
  localparam int          TMO_CYC = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  iob_split_tmo_if #(.ADDR_W(32), .DATA_W(32), .N_SLAVES(4)) if0 ();
  iob_split_tmo_if #(.ADDR_W(32), .DATA_W(32), .N_SLAVES(3)) if1 ();

  iob_split_tmo #(.N_SLAVES(4), .SEL_W(2), .P_SLAVES(31), .REQ_REG(0), .TMO_W(4))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  iob_split_tmo #(.N_SLAVES(3), .SEL_W(2), .P_SLAVES(31), .REQ_REG(1), .TMO_W(4))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  logic        mv  [2];
  logic [31:0] ma  [2];
  logic [31:0] mw  [2];
  logic [3:0]  ms  [2];
  logic [3:0]  sr  [2];
  logic [31:0] srd [2][4];

  assign if0.m_valid = mv[0];  assign if1.m_valid = mv[1];
  assign if0.m_addr  = ma[0];  assign if1.m_addr  = ma[1];
  assign if0.m_wdata = mw[0];  assign if1.m_wdata = mw[1];
  assign if0.m_wstrb = ms[0];  assign if1.m_wstrb = ms[1];
  assign if0.s_ready = sr[0];  assign if1.s_ready = sr[1][2:0];
  assign if0.s_rdata = {srd[0][3], srd[0][2], srd[0][1], srd[0][0]};
  assign if1.s_rdata = {srd[1][2], srd[1][1], srd[1][0]};

  logic [3:0]  svo [2];
  logic        mr  [2];
  logic [31:0] mrd [2];
  logic [31:0] sad [2];
  logic [31:0] swd [2];
  logic [3:0]  sst [2];
  logic [15:0] ecn [2];
  logic [31:0] ead [2];
  logic        etm [2];

  assign svo[0] = if0.s_valid;   assign svo[1] = {1'b0, if1.s_valid};
  assign mr[0]  = if0.m_ready;   assign mr[1]  = if1.m_ready;
  assign mrd[0] = if0.m_rdata;   assign mrd[1] = if1.m_rdata;
  assign sad[0] = if0.s_addr;    assign sad[1] = if1.s_addr;
  assign swd[0] = if0.s_wdata;   assign swd[1] = if1.s_wdata;
  assign sst[0] = if0.s_wstrb;   assign sst[1] = if1.s_wstrb;
  assign ecn[0] = if0.err_cnt;   assign ecn[1] = if1.err_cnt;
  assign ead[0] = if0.err_addr;  assign ead[1] = if1.err_addr;
  assign etm[0] = if0.err_tmo;   assign etm[1] = if1.err_tmo;

  int n_chk = 0;
  int n_fail = 0;

  // Reference state: last completed read data and the error log, per unit.
  logic [31:0] last_rd [2];
  int          m_ecnt  [2];
  logic [31:0] m_eaddr [2];
  logic        m_etmo  [2];

  typedef struct {
    int          u;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  st;
    int          d;
    logic [31:0] rd;
    bit          stray;
    int          e_lat;
    logic [31:0] e_rd;
    bit          e_err;
    bit          e_tmo;
  } vec_t;

  vec_t vt [9];

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic void check_log(input int u);
    check("err_cnt", 32'(ecn[u]), 32'(m_ecnt[u]));
    check("err_addr", ead[u], m_eaddr[u]);
    check("err_tmo", 32'(etm[u]), 32'(m_etmo[u]));
  endfunction

  function automatic void reset_model();
    for (int u = 0; u < 2; u++) begin
      last_rd[u] = '0; m_ecnt[u] = 0; m_eaddr[u] = '0; m_etmo[u] = 1'b0;
    end
  endfunction

  // Completion rules: unmapped -> 1 cycle error; slave reply in BUSY cycle d
  // wins up to and including the 16th BUSY cycle; otherwise a timeout at 16.
  function automatic void predict(input int u, input logic [31:0] a, input int d,
                                  input logic [31:0] rd, output int lat,
                                  output logic [31:0] erd, output bit err, output bit tmo);
    int nsl = (u == 0) ? 4 : 3;
    if (int'(a[31:30]) >= nsl) begin
      lat = 1; erd = ERRD; err = 1'b1; tmo = 1'b0;
    end else if (d >= 1 && d <= TMO_CYC) begin
      lat = d; erd = rd; err = 1'b0; tmo = 1'b0;
    end else begin
      lat = TMO_CYC; erd = ERRD; err = 1'b1; tmo = 1'b1;
    end
  endfunction

  // Starts at posedge+1; cycle 0 is the cycle m_valid first rises.
  task automatic txn(input int u, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] st, input int d, input logic [31:0] rd,
                     input bit stray, input int e_lat, input logic [31:0] e_rd,
                     input bit e_err, input bit e_tmo, input int gap);
    int         nsl = (u == 0) ? 4 : 3;
    logic [1:0] sel = a[31:30];
    logic [3:0] oh  = 4'b0001 << sel;
    bit         mapped = (int'(sel) < nsl);
    bit         done = 1'b0;
    logic [3:0] exp_sv;
    mv[u] = 1'b1; ma[u] = a; mw[u] = wd; ms[u] = st;
    for (int c = 0; c <= 40 && !done; c++) begin
      sr[u] = '0;
      for (int k = 0; k < 4; k++) srd[u][k] = $urandom;
      if (mapped && c == d) begin
        sr[u][sel] = 1'b1;
        srd[u][sel] = rd;
      end
      if (stray) sr[u] = sr[u] | (4'($urandom) & ~oh);
      @(negedge clk);
      exp_sv = (mapped && c <= e_lat && (c >= 1 || u == 0)) ? oh : 4'b0000;
      check("s_valid", 32'(svo[u]), 32'(exp_sv));
      if (exp_sv != 4'b0000) begin
        check("s_addr", sad[u], a);
        check("s_wdata", swd[u], wd);
        check("s_wstrb", 32'(sst[u]), 32'(st));
      end else begin
        check("s_wstrb_idle", 32'(sst[u]), 32'h0);
      end
      check("m_ready", 32'(mr[u]), 32'(c == e_lat));
      if (c == e_lat) check("m_rdata", mrd[u], e_rd);
      else if (u == 0) check("m_rdata_hold", mrd[u], last_rd[u]);
      if (mr[u] === 1'b1) done = 1'b1;
      @(posedge clk); #1;
    end
    check("completion_seen", 32'(done), 32'h1);
    mv[u] = 1'b0; sr[u] = '0;
    last_rd[u] = e_rd;
    if (e_err) begin
      if (m_ecnt[u] < 65535) m_ecnt[u]++;
      m_eaddr[u] = a;
      m_etmo[u]  = e_tmo;
    end
    check_log(u);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      check("s_valid_after", 32'(svo[u]), 32'h0);
      check("m_ready_after", 32'(mr[u]), 32'h0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] erd;
    bit          err, tmo;

    for (int u = 0; u < 2; u++) begin
      mv[u] = 1'b0; ma[u] = '0; mw[u] = '0; ms[u] = '0; sr[u] = '0;
      for (int k = 0; k < 4; k++) srd[u][k] = '0;
    end
    reset_model();

    //            u  addr           wdata          st    d   slave rdata    str lat erd            err tmo
    vt[0] = '{0, 32'h8000_0010, 32'h0000_0000, 4'h0,  3, 32'h1234_5678, 0,  3, 32'h1234_5678, 0, 0};
    vt[1] = '{1, 32'h4000_0020, 32'hA5A5_A5A5, 4'hF,  2, 32'h5A5A_0001, 0,  2, 32'h5A5A_0001, 0, 0};
    vt[2] = '{1, 32'hC000_0000, 32'h0000_0000, 4'h0,  1, 32'h0000_0000, 1,  1, 32'hDEAD_BEEF, 1, 0};
    vt[3] = '{0, 32'h0000_0100, 32'h0000_0000, 4'h0, 99, 32'h0000_0000, 0, 16, 32'hDEAD_BEEF, 1, 1};
    vt[4] = '{0, 32'h0000_0200, 32'h0000_0000, 4'h0, 16, 32'hCAFE_0016, 1, 16, 32'hCAFE_0016, 0, 0};
    vt[5] = '{0, 32'hC000_0004, 32'h0123_4567, 4'h3,  1, 32'h0BAD_F00D, 1,  1, 32'h0BAD_F00D, 0, 0};
    vt[6] = '{1, 32'h8000_0008, 32'h0000_0000, 4'h0, 16, 32'h7777_0002, 0, 16, 32'h7777_0002, 0, 0};
    vt[7] = '{1, 32'h0000_0040, 32'h0000_0000, 4'h0, 50, 32'h0000_0000, 0, 16, 32'hDEAD_BEEF, 1, 1};
    vt[8] = '{1, 32'h8000_0000, 32'h0000_0000, 4'h0,  5, 32'h1111_2222, 1,  5, 32'h1111_2222, 0, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("rst_s_valid", 32'(svo[u]), 32'h0);
      check("rst_m_ready", 32'(mr[u]), 32'h0);
      check("rst_m_rdata", mrd[u], 32'h0);
      check_log(u);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vt[i])
      txn(vt[i].u, vt[i].a, vt[i].wd, vt[i].st, vt[i].d, vt[i].rd, vt[i].stray,
          vt[i].e_lat, vt[i].e_rd, vt[i].e_err, vt[i].e_tmo, 1);

    // Reset while both units are waiting on slave 1.
    mv[0] = 1'b1; ma[0] = 32'h4000_0000;
    mv[1] = 1'b1; ma[1] = 32'h4000_0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("busy_s_valid_u0", 32'(svo[0]), 32'h2);
    check("busy_s_valid_u1", 32'(svo[1]), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    reset_model();
    for (int u = 0; u < 2; u++) begin
      check("midrst_s_valid", 32'(svo[u]), 32'h0);
      check("midrst_m_ready", 32'(mr[u]), 32'h0);
      check("midrst_m_rdata", mrd[u], 32'h0);
      check_log(u);
    end
    mv[0] = 1'b0; mv[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn(0, 32'h4000_0000, 32'h0, 4'h0, 4, 32'h600D_0004, 0, 4, 32'h600D_0004, 0, 0, 0);
    txn(1, 32'h4000_0000, 32'h0, 4'h0, 3, 32'h600D_0103, 0, 3, 32'h600D_0103, 0, 0, 0);

    for (int i = 0; i < 200; i++) begin
      int          u  = int'($urandom_range(0, 1));
      logic [31:0] a  = $urandom;
      logic [31:0] wd = $urandom;
      logic [3:0]  st = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      int          d  = int'($urandom_range(1, 20));
      logic [31:0] rd = $urandom;
      bit          sy = 1'($urandom_range(0, 1));
      int          gp = int'($urandom_range(0, 2));
      predict(u, a, d, rd, lat, erd, err, tmo);
      txn(u, a, wd, st, d, rd, sy, lat, erd, err, tmo, gp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
